uart_tx_ctrl: RTL and testbench

UART transmit frame controller. It accepts one character per valid/ready handshake, then serialises it onto `tx_o` as start bit, 5–8 data bits LSB-first, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an external 16x-baud tick. It sits between the APB register/FIFO side of the transmitter and the TX pin, and owns the sequencing of the parity generation.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/tx_parity_calc.sv | 19 +
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the controller state encoding, data-length encoding and latched frame config.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    LEN5 = 2'b00,
    LEN6 = 2'b01,
    LEN7 = 2'b10,
    LEN8 = 2'b11
  } data_len_e;

  typedef struct packed {
    logic      parity_en;
    logic      parity_type;
    data_len_e len;
    logic      stop2;
  } tx_cfg_t;

  function automatic logic [3:0] data_bits(input data_len_e len);
    return 4'd5 + {2'b00, len};
  endfunction

endpackage

// File: rtl/tx_parity_calc.sv
// Combinational parity over the low N = 5..8 data bits; bits above N never contribute.
// parity_type = 1 gives even parity (plain XOR), 0 gives odd (inverted XOR).
module tx_parity_calc
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] len,
  input  logic       parity_type,
  output logic       parity_bit
);

  logic [7:0] mask;
  logic       xor_red;

  assign mask       = 8'hFF >> (4'd8 - data_bits(data_len_e'(len)));
  assign xor_red    = ^(data & mask);
  assign parity_bit = parity_type ? xor_red : ~xor_red;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame serialiser: start, 5-8 data bits LSB-first, optional parity, 1-2 stop bits.
// Accepts one character per valid/ready handshake while idle; all outputs registered.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  input  logic [1:0] data_len_i,
  input  logic       stop2_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int TW = $clog2(OVERSAMPLE);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  tx_cfg_t       cfg_q, cfg_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          accept, bit_adv, last_data, last_stop, par_bit;

  assign accept    = valid_i && (state_q == IDLE);
  assign bit_adv   = (state_q != IDLE) && tick_i && (tick_cnt_q == TW'(OVERSAMPLE - 1));
  assign last_data = ({1'b0, bit_cnt_q} == (data_bits(cfg_q.len) - 4'd1));
  assign last_stop = (bit_cnt_q == {2'b00, cfg_q.stop2});

  tx_parity_calc u_parity (
    .data        (data_q),
    .len         (cfg_q.len),
    .parity_type (cfg_q.parity_type),
    .parity_bit  (par_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                state_d = START;
      START:   if (bit_adv)               state_d = DATA;
      DATA:    if (bit_adv && last_data)  state_d = cfg_q.parity_en ? PARITY : STOP;
      PARITY:  if (bit_adv)               state_d = STOP;
      STOP:    if (bit_adv && last_stop)  state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // bit_cnt restarts at 0 on every state change, so STOP reuses it for stop bits
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    cfg_d      = cfg_q;
    if (accept) begin
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = data_i;
      data_d     = data_i;
      cfg_d      = '{parity_en: parity_en_i, parity_type: parity_type_i,
                     len: data_len_e'(data_len_i), stop2: stop2_i};
    end else if (state_q != IDLE && tick_i) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
      if (bit_adv) begin
        bit_cnt_d = (state_d != state_q) ? 3'd0 : bit_cnt_q + 3'd1;
        if (state_q == DATA) shift_d = shift_q >> 1;
      end
    end
  end

  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      cfg_q      <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      cfg_q      <= cfg_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);
  assign tx_o    = tx_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a tick-counting frame model checks every pin every cycle,
// plus a table of hand-derived frames and directed back-to-back / mid-frame reset sequences.
module tb_uart_tx_ctrl;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset, tick_i, valid_i, ready_o, parity_en_i, parity_type_i, stop2_i;
  logic       tx_o, busy_o, done_o;
  logic [7:0] data_i;
  logic [1:0] data_len_i;

  uart_tx_ctrl #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .tick_i(tick_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .parity_en_i(parity_en_i), .parity_type_i(parity_type_i),
    .data_len_i(data_len_i), .stop2_i(stop2_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        pt;
    logic [1:0]  len;
    logic        s2;
    int          tp;
    logic [11:0] bits;
    int          nbits;
  } vec_t;

  int checks = 0, errors = 0;
  int tick_per = 1, cyc = 0, done_cnt = 0, acc_cyc = 0, dut_done_cyc = 0;
  bit m_busy = 0, m_done = 0, scramble = 0;
  int m_k = 0, m_nbits = 0;
  logic [11:0] m_bits = '0;
  logic [11:0] cap = '0;

  // Frame as the list of line levels, one per bit period, index 0 = start bit.
  task automatic build(input logic [7:0] d, input logic pe, input logic pt,
                       input logic [1:0] len, input logic s2);
    int n, idx;
    logic x;
    n = 5 + int'(len);
    x = 1'b0;
    m_bits = '0;
    for (int j = 0; j < n; j++) begin
      m_bits[1+j] = d[j];
      x = x ^ d[j];
    end
    idx = 1 + n;
    if (pe) begin
      m_bits[idx] = pt ? x : ~x;
      idx++;
    end
    m_bits[idx] = 1'b1;
    idx++;
    if (s2) begin
      m_bits[idx] = 1'b1;
      idx++;
    end
    m_nbits = idx;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic exp_tx;
    tick_i = ((cyc % tick_per) == 0);
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_busy = 0;
      m_done = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (valid_i) begin
        build(data_i, parity_en_i, parity_type_i, data_len_i, stop2_i);
        m_busy  = 1;
        m_k     = 0;
        cap     = '0;
        acc_cyc = cyc;
      end
    end else begin
      m_done = 0;
      if (tick_i) begin
        m_k++;
        if (m_k == OS * m_nbits) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    #1;
    exp_tx = m_busy ? m_bits[m_k/OS] : 1'b1;
    check("pins tx/ready/busy/done", {28'd0, tx_o, ready_o, busy_o, done_o},
          {28'd0, exp_tx, ~m_busy, m_busy, m_done});
    if (m_busy && (m_k % OS) == OS/2) cap[m_k/OS] = tx_o;
    if (done_o === 1'b1) begin
      done_cnt++;
      dut_done_cyc = cyc;
    end
    if (scramble && m_busy) begin
      data_i        = 8'($urandom);
      data_len_i    = 2'($urandom);
      parity_en_i   = 1'($urandom);
      parity_type_i = 1'($urandom);
      stop2_i       = 1'($urandom);
    end
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int d0, budget;
    data_i = v.d; parity_en_i = v.pe; parity_type_i = v.pt;
    data_len_i = v.len; stop2_i = v.s2; tick_per = v.tp;
    d0 = done_cnt;
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    scramble = 1;
    budget = 0;
    while (m_busy && budget < 4*OS*12 + 20) begin
      cycle();
      budget++;
    end
    scramble = 0;
    repeat (2) cycle();
    check({name, " serial bits"}, 32'(cap), 32'(v.bits));
    check({name, " done pulses"}, done_cnt - d0, 1);
    if (v.tp == 1) check({name, " frame cycles"}, dut_done_cyc - acc_cyc, OS * v.nbits);
  endtask

  vec_t tbl[7];

  initial begin
    int d0, budget, rst_at;
    tbl[0] = '{8'h55, 1'b0, 1'b0, 2'd3, 1'b0, 1, 12'h2AA, 10};  // 8N1
    tbl[1] = '{8'hA3, 1'b1, 1'b1, 2'd3, 1'b0, 1, 12'h546, 11};  // 8E1
    tbl[2] = '{8'hA3, 1'b1, 1'b0, 2'd3, 1'b0, 1, 12'h746, 11};  // 8O1
    tbl[3] = '{8'hFF, 1'b1, 1'b0, 2'd0, 1'b1, 1, 12'h1BE, 9};   // 5O2
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 2'd2, 1'b0, 2, 12'h3FE, 10};  // 7E1
    tbl[5] = '{8'hC5, 1'b0, 1'b0, 2'd1, 1'b1, 3, 12'h18A, 9};   // 6N2
    tbl[6] = '{8'h3C, 1'b0, 1'b0, 2'd3, 1'b0, 4, 12'h278, 10};  // 8N1 after reset

    reset = 1'b1; valid_i = 1'b0; data_i = '0; parity_en_i = 1'b0;
    parity_type_i = 1'b0; data_len_i = '0; stop2_i = 1'b0; tick_i = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (100) cycle();
    check("idle done pulses", done_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i], $sformatf("vec%0d", i));
      repeat (3) cycle();
    end

    // back-to-back with valid held; data_len toggles during the first frame
    tick_per = 1; data_i = 8'h01; parity_en_i = 1'b0; stop2_i = 1'b0; data_len_i = 2'd3;
    valid_i = 1'b1;
    cycle();
    data_i = 8'h80;
    budget = 0;
    while (m_busy && budget < OS*12 + 20) begin
      data_len_i = (m_k < OS*5) ? 2'($urandom) : 2'd3;
      cycle();
      budget++;
    end
    check("b2b first bits", 32'(cap), 32'h202);
    check("b2b gap cycle tx/done", {30'd0, tx_o, done_o}, 32'h3);
    cycle();
    check("b2b restart tx/ready", {30'd0, tx_o, ready_o}, 32'h0);
    valid_i = 1'b0;
    budget = 0;
    while (m_busy && budget < OS*12 + 20) begin
      cycle();
      budget++;
    end
    check("b2b second bits", 32'(cap), 32'h300);
    repeat (3) cycle();

    // reset in the middle of DATA with a slow tick
    tick_per = 4; data_i = 8'h55; data_len_i = 2'd3;
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    budget = 0;
    while (m_k < OS*3 && budget < 4*OS*4) begin
      cycle();
      budget++;
    end
    d0 = done_cnt;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("post-reset tx/ready/busy", {29'd0, tx_o, ready_o, busy_o}, 32'h6);
    repeat (20) cycle();
    check("post-reset done pulses", done_cnt - d0, 0);
    run_frame(tbl[6], "vec6");

    // random frames, config scrambled mid-frame, occasional reset
    for (int r = 0; r < 30; r++) begin
      tick_per = $urandom_range(1, 3);
      data_i = 8'($urandom); data_len_i = 2'($urandom); parity_en_i = 1'($urandom);
      parity_type_i = 1'($urandom); stop2_i = 1'($urandom);
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 200)) : -1;
      valid_i = 1'b1;
      cycle();
      valid_i = 1'b0;
      scramble = 1;
      budget = 0;
      while (m_busy && budget < 3*OS*12 + 20) begin
        reset = (budget == rst_at);
        cycle();
        budget++;
      end
      reset = 1'b0;
      scramble = 0;
      repeat ($urandom_range(0, 4)) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
